// File: rtl/exu_oitf.sv
`default_nettype none
// ============================================================================
// Module   : exu_oitf
// Brief    : Outstanding Instruction Track FIFO. Tags long-pipe instructions
//            at dispatch, flags RAW/WAW hazards, frees entries in order.
// Revision : 1.0
// ============================================================================
module exu_oitf #(
    parameter int OITF_DEPTH  = 4,
    parameter int ITAG_WIDTH  = 2,
    parameter int RFIDX_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   disp_oitf_ena,
    output logic                   disp_oitf_ready,
    output logic [ITAG_WIDTH-1:0]  disp_oitf_ptr,
    input  logic                   disp_oitf_rs1en,
    input  logic                   disp_oitf_rs2en,
    input  logic                   disp_oitf_rdwen,
    input  logic [RFIDX_WIDTH-1:0] disp_oitf_rs1idx,
    input  logic [RFIDX_WIDTH-1:0] disp_oitf_rs2idx,
    input  logic [RFIDX_WIDTH-1:0] disp_oitf_rdidx,
    output logic                   oitfrd_match_disprs1,
    output logic                   oitfrd_match_disprs2,
    output logic                   oitfrd_match_disprd,
    output logic                   oitf_empty,
    input  logic                   oitf_ret_ena,
    output logic [ITAG_WIDTH-1:0]  oitf_ret_ptr,
    output logic                   oitf_ret_rdwen,
    output logic [RFIDX_WIDTH-1:0] oitf_ret_rdidx
);

    localparam logic [ITAG_WIDTH:0]  c_CNT_ONE  = {{ITAG_WIDTH{1'b0}}, 1'b1};
    localparam logic [RFIDX_WIDTH-1:0] c_X0     = '0;

    // Counters carry the wrap flag in their MSB; depth is a power of two,
    // so a plain increment wraps the index and toggles the flag together.
    logic [ITAG_WIDTH:0]    r_alloc_cnt;
    logic [ITAG_WIDTH:0]    r_ret_cnt;
    logic [OITF_DEPTH-1:0]  r_vld;
    logic [OITF_DEPTH-1:0]  r_rdwen;
    logic [RFIDX_WIDTH-1:0] r_rdidx [OITF_DEPTH];

    logic [ITAG_WIDTH-1:0]  w_alloc_ptr;
    logic [ITAG_WIDTH-1:0]  w_ret_ptr;
    logic                   w_ptr_eq;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_alloc;
    logic                   w_ret;
    logic [OITF_DEPTH-1:0]  w_hit_rs1;
    logic [OITF_DEPTH-1:0]  w_hit_rs2;
    logic [OITF_DEPTH-1:0]  w_hit_rd;

    assign w_alloc_ptr = r_alloc_cnt[ITAG_WIDTH-1:0];
    assign w_ret_ptr   = r_ret_cnt[ITAG_WIDTH-1:0];
    assign w_ptr_eq    = (w_alloc_ptr == w_ret_ptr);
    assign w_empty     = w_ptr_eq & (r_alloc_cnt[ITAG_WIDTH] == r_ret_cnt[ITAG_WIDTH]);
    assign w_full      = w_ptr_eq & (r_alloc_cnt[ITAG_WIDTH] != r_ret_cnt[ITAG_WIDTH]);
    assign w_alloc     = disp_oitf_ena & ~w_full;
    assign w_ret       = oitf_ret_ena & ~w_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_alloc_cnt <= '0;
            r_ret_cnt   <= '0;
        end else begin
            if (w_alloc) begin
                r_alloc_cnt <= r_alloc_cnt + c_CNT_ONE;
            end
            if (w_ret) begin
                r_ret_cnt <= r_ret_cnt + c_CNT_ONE;
            end
        end
    end

    // Alloc and retire can never target the same slot: that needs equal
    // pointers, which means either full (no alloc) or empty (no retire).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld   <= '0;
            r_rdwen <= '0;
            for (int i = 0; i < OITF_DEPTH; i++) begin
                r_rdidx[i] <= '0;
            end
        end else begin
            if (w_ret) begin
                r_vld[w_ret_ptr] <= 1'b0;
            end
            if (w_alloc) begin
                r_vld[w_alloc_ptr]   <= 1'b1;
                r_rdwen[w_alloc_ptr] <= disp_oitf_rdwen;
                r_rdidx[w_alloc_ptr] <= disp_oitf_rdidx;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < OITF_DEPTH; gi++) begin : g_hit
            assign w_hit_rs1[gi] = r_vld[gi] & r_rdwen[gi] & (r_rdidx[gi] == disp_oitf_rs1idx);
            assign w_hit_rs2[gi] = r_vld[gi] & r_rdwen[gi] & (r_rdidx[gi] == disp_oitf_rs2idx);
            assign w_hit_rd[gi]  = r_vld[gi] & r_rdwen[gi] & (r_rdidx[gi] == disp_oitf_rdidx);
        end
    endgenerate

    // x0 is hardwired zero, so it never carries a dependency.
    assign oitfrd_match_disprs1 = disp_oitf_rs1en & (disp_oitf_rs1idx != c_X0) & (|w_hit_rs1);
    assign oitfrd_match_disprs2 = disp_oitf_rs2en & (disp_oitf_rs2idx != c_X0) & (|w_hit_rs2);
    assign oitfrd_match_disprd  = disp_oitf_rdwen & (disp_oitf_rdidx  != c_X0) & (|w_hit_rd);

    assign disp_oitf_ready = ~w_full;
    assign disp_oitf_ptr   = w_alloc_ptr;
    assign oitf_empty      = w_empty;
    assign oitf_ret_ptr    = w_ret_ptr;
    assign oitf_ret_rdwen  = r_vld[w_ret_ptr] & r_rdwen[w_ret_ptr];
    assign oitf_ret_rdidx  = r_rdidx[w_ret_ptr] & {RFIDX_WIDTH{r_vld[w_ret_ptr]}};

endmodule
`default_nettype wire

// File: doc/exu_oitf.md
Name: exu_oitf

Overview:
- Outstanding Instruction Track FIFO: the responder end of the dispatch-to-OITF interface.
- Allocates one entry per long-pipe instruction (load/store, mul/div) accepted by dispatch.
- Returns an instruction tag (ITAG) to the dispatcher and flags RAW/WAW hazards against in-flight destinations.
- Frees entries in order when the long-pipe writeback retires them.

Parameters:
- OITF_DEPTH, 4, number of entries; power of two, >= 2.
- ITAG_WIDTH, 2, log2(OITF_DEPTH); width of entry tags.
- RFIDX_WIDTH, 5, register-file index width.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- disp_oitf_ena  input  1  allocate one entry this cycle
- disp_oitf_ready  output  1  an entry is free
- disp_oitf_ptr  output  ITAG_WIDTH  tag the next allocation will receive
- disp_oitf_rs1en  input  1  dispatching instruction reads rs1
- disp_oitf_rs2en  input  1  dispatching instruction reads rs2
- disp_oitf_rdwen  input  1  dispatching instruction writes rd
- disp_oitf_rs1idx  input  RFIDX_WIDTH  rs1 index
- disp_oitf_rs2idx  input  RFIDX_WIDTH  rs2 index
- disp_oitf_rdidx  input  RFIDX_WIDTH  rd index
- oitfrd_match_disprs1  output  1  rs1 matches an in-flight rd
- oitfrd_match_disprs2  output  1  rs2 matches an in-flight rd
- oitfrd_match_disprd  output  1  rd matches an in-flight rd
- oitf_empty  output  1  no entries in flight
- oitf_ret_ena  input  1  long-pipe writeback retires the oldest entry
- oitf_ret_ptr  output  ITAG_WIDTH  tag of the oldest entry
- oitf_ret_rdwen  output  1  oldest entry writes rd
- oitf_ret_rdidx  output  RFIDX_WIDTH  oldest entry rd index

Behaviour:
Clock and reset:
- Single clock domain.
- rst is synchronous and active-high.
- On reset: alloc_ptr=0, ret_ptr=0, both wrap flags=0, all valid bits=0, stored rdwen/rdidx=0.

Reset values of outputs (combinational from state):
- disp_oitf_ready=1, oitf_empty=1, disp_oitf_ptr=0, oitf_ret_ptr=0.
- All match outputs=0, oitf_ret_rdwen=0, oitf_ret_rdidx=0.

Storage:
- Circular buffer of OITF_DEPTH entries, each holding {valid, rdwen, rdidx}.
- alloc_ptr and ret_ptr each carry an extra wrap bit.
- empty = (ptrs equal) & (wrap bits equal).
- full = (ptrs equal) & (wrap bits differ).
- disp_oitf_ready = ~full.
- disp_oitf_ptr = alloc_ptr.
- oitf_ret_ptr = ret_ptr.
- oitf_ret_rdwen/rdidx = entry[ret_ptr] fields, gated by entry valid.

Allocate:
- Condition: disp_oitf_ena & ~full.
- At the clock edge, entry[alloc_ptr] <= {1, disp_oitf_rdwen, disp_oitf_rdidx}.
- alloc_ptr increments; wrap bit toggles when it passes OITF_DEPTH-1 back to 0.
- disp_oitf_ena while full: ignored, no state change; the bench flags it as a protocol error.

Retire:
- Condition: oitf_ret_ena & ~empty.
- entry[ret_ptr].valid <= 0; ret_ptr increments with the same wrap rule.
- oitf_ret_ena while empty: ignored.

Simultaneous allocate and retire:
- Both take effect in the same cycle; occupancy is unchanged.
- Full is evaluated on pre-edge state: if full, the allocation is refused even when a retire occurs in the same cycle (no bypass).

Hazard match (combinational, pre-edge state only):
- match_rs1 = rs1en & OR over entries of (valid & rdwen & rdidx==rs1idx & rs1idx!=0).
- match_rs2: same form, using rs2en and rs2idx.
- match_rd: same form, using disp rdwen and rdidx.
- A same-cycle retire does not clear a match; this is conservative and costs one stall cycle.
- A same-cycle allocate is not visible to its own match check.
- Index x0 never produces a match.

Latency:
- Allocation is visible to ptr, empty, ready and matches in the cycle after the edge.

Reset mid-operation:
- All entries are discarded and the block returns to its reset values on the next edge, regardless of ena inputs.

Test Plan:
- Reset, then idle: ready=1, empty=1, ptr=0, all matches 0.
- Allocate rd=5, 4 times with no retire -> ptr sequence 0,1,2,3 then 0. After the 4th allocation: ready=0, empty=0. A 5th ena is ignored and ptr stays 0.
- One entry in flight with rd=7: present rs1idx=7, rs1en=1 -> match_rs1=1. With rs1en=0 -> 0. rdidx=7 with rdwen=1 -> match_rd=1. rd=0 entry vs rs1idx=0 -> 0.
- Full FIFO, assert ret_ena and disp_oitf_ena together -> allocation refused, ret_ptr 0->1, ready=1 next cycle. Repeat at 3 entries -> both accepted, occupancy stays 3.
- Retire all entries across the wrap -> ret_rdidx follows allocation order, empty=1 after the last retire. A further ret_ena causes no ptr change.
- rst asserted with 3 entries in flight and ena high -> next cycle matches reset values exactly (ptrs 0, empty=1).
